// File: rtl/gf2_elim_pkg.sv
// Shared types and widths for the GF(2) Gauss-Jordan elimination controller.
package gf2_elim_pkg;

  localparam int AW = 8;  // RAM row address width
  localparam int RW = 9;  // rank width, counts up to 256

  typedef enum logic [2:0] {
    IDLE,
    SRCH,
    SWAP0,
    SWAP1,
    ELIM,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/gf2_elim_ctrl_if.sv
// Matrix RAM port bundle: one write port and one read port with 1-cycle read latency.
// The master drives the request side; the slave returns read data.
interface gf2_elim_ctrl_if #(
  parameter int N = 128
);
  import gf2_elim_pkg::*;

  logic          wr_en;
  logic [AW-1:0] w_addr;
  logic [N:0]    w_data;
  logic [AW-1:0] r_addr;
  logic [N:0]    r_data;

  modport master (output wr_en, w_addr, w_data, r_addr, input r_data);
  modport slave  (input wr_en, w_addr, w_data, r_addr, output r_data);

endinterface

// File: rtl/gf2_row_update.sv
// Elimination step for one returned row: XOR with the pivot row, and decide
// whether the result must be written back (bit col set and not the pivot row).
module gf2_row_update
  import gf2_elim_pkg::*;
#(
  parameter int N  = 128,
  parameter int CW = 8
) (
  input  logic [N:0]    row,
  input  logic [N:0]    piv,
  input  logic [CW-1:0] col,
  input  logic [AW-1:0] row_idx,
  input  logic [AW-1:0] prow_idx,
  input  logic          vld,
  output logic          we,
  output logic [N:0]    new_row
);

  genvar gi;
  generate
    for (gi = 0; gi <= N; gi++) begin : g_xor
      assign new_row[gi] = row[gi] ^ piv[gi];
    end
  endgenerate

  assign we = vld && row[col] && (row_idx != prow_idx);

endmodule

// File: rtl/gf2_elim_ctrl.sv
// In-place Gauss-Jordan elimination over GF(2) on an M x (N+1) augmented
// matrix held in an external RAM. Host accesses are forwarded while idle.
// Optional macro GF2_ELIM_CONSIST_EN: adds the CHECK scan that computes
// 'consistent'; without it 'consistent' is tied high.
module gf2_elim_ctrl
  import gf2_elim_pkg::*;
#(
  parameter int M = 256,
  parameter int N = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [RW-1:0]   rank,
  output logic            consistent,
  gf2_elim_ctrl_if.slave  host,
  gf2_elim_ctrl_if.master ram
);

  localparam int            CW       = $clog2(N + 1);
  localparam logic [AW-1:0] LAST_ROW = AW'(M - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(N - 1);
  localparam logic [RW-1:0] M_RW     = RW'(M);

  state_t        state_reg;
  logic          busy_reg;
  logic          done_reg;
  logic [CW-1:0] col_reg;
  logic [RW-1:0] prow_reg;   // next pivot row; always equal to the rank so far
  logic [AW-1:0] p_reg;      // row index of the pivot found by SRCH
  logic [N:0]    top_reg;    // original contents of row prow
  logic [N:0]    piv_reg;    // pivot row data
  logic [AW-1:0] addr_reg;   // read address being issued
  logic          issue_reg;  // a scan read is issued this cycle
  logic          vld_reg;    // ram.r_data belongs to row rrow_reg this cycle
  logic [AW-1:0] rrow_reg;
`ifdef GF2_ELIM_CONSIST_EN
  logic          cons_reg;
`endif

  logic [N:0]    rd_data;
  logic [RW-1:0] prow_inc;
  logic          upd_we;
  logic [N:0]    upd_row;

  assign rd_data  = ram.r_data;
  assign prow_inc = prow_reg + 1'b1;

  assign busy = busy_reg;
  assign done = done_reg;
  assign rank = prow_reg;
`ifdef GF2_ELIM_CONSIST_EN
  assign consistent = cons_reg;
`else
  assign consistent = 1'b1;
`endif

  gf2_row_update #(
    .N (N),
    .CW(CW)
  ) u_row_update (
    .row     (rd_data),
    .piv     (piv_reg),
    .col     (col_reg),
    .row_idx (rrow_reg),
    .prow_idx(prow_reg[AW-1:0]),
    .vld     (vld_reg),
    .we      (upd_we),
    .new_row (upd_row)
  );

  // RAM port mux: host passes through while not busy, controller drives otherwise
  always_comb begin
    host.r_data = ram.r_data;
    ram.wr_en   = 1'b0;
    ram.w_addr  = rrow_reg;
    ram.w_data  = upd_row;
    ram.r_addr  = addr_reg;
    if (!busy_reg) begin
      ram.wr_en  = host.wr_en;
      ram.w_addr = host.w_addr;
      ram.w_data = host.w_data;
      ram.r_addr = host.r_addr;
    end else begin
      case (state_reg)
        SWAP0: begin
          ram.wr_en  = 1'b1;
          ram.w_addr = prow_reg[AW-1:0];
          ram.w_data = piv_reg;
        end
        SWAP1: begin
          ram.wr_en  = 1'b1;
          ram.w_addr = p_reg;
          ram.w_data = top_reg;
        end
        ELIM: begin
          ram.wr_en  = upd_we;
          ram.w_addr = rrow_reg;
          ram.w_data = upd_row;
        end
        default: ram.wr_en = 1'b0;
      endcase
    end
  end

  // Sequencer: read-scan pipeline plus pivot search, swap, elimination and check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      col_reg   <= '0;
      prow_reg  <= '0;
      p_reg     <= '0;
      top_reg   <= '0;
      piv_reg   <= '0;
      addr_reg  <= '0;
      issue_reg <= 1'b0;
      vld_reg   <= 1'b0;
      rrow_reg  <= '0;
`ifdef GF2_ELIM_CONSIST_EN
      cons_reg  <= 1'b1;
`endif
    end else begin
      // Default scan pipeline: data returns one cycle after its address
      vld_reg  <= issue_reg;
      rrow_reg <= addr_reg;
      if (issue_reg) begin
        if (addr_reg == LAST_ROW) issue_reg <= 1'b0;
        else                      addr_reg  <= addr_reg + 1'b1;
      end

      case (state_reg)
        IDLE, DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
          if (start) begin
            state_reg <= SRCH;
            busy_reg  <= 1'b1;
            col_reg   <= '0;
            prow_reg  <= '0;
            addr_reg  <= '0;
            issue_reg <= 1'b1;
            vld_reg   <= 1'b0;
`ifdef GF2_ELIM_CONSIST_EN
            cons_reg  <= 1'b1;
`endif
          end
        end

        SRCH: begin
          if (vld_reg) begin
            if ({1'b0, rrow_reg} == prow_reg) top_reg <= rd_data;
            if (rd_data[col_reg]) begin
              // Pivot found: drop the reads still in flight
              piv_reg   <= rd_data;
              p_reg     <= rrow_reg;
              issue_reg <= 1'b0;
              vld_reg   <= 1'b0;
              if ({1'b0, rrow_reg} != prow_reg) begin
                state_reg <= SWAP0;
              end else begin
                state_reg <= ELIM;
                addr_reg  <= '0;
                issue_reg <= 1'b1;
              end
            end else if (rrow_reg == LAST_ROW) begin
              if (col_reg == LAST_COL) begin
`ifdef GF2_ELIM_CONSIST_EN
                state_reg <= CHECK;
                addr_reg  <= prow_reg[AW-1:0];
                issue_reg <= 1'b1;
                vld_reg   <= 1'b0;
`else
                state_reg <= DONE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
`endif
              end else begin
                col_reg   <= col_reg + 1'b1;
                addr_reg  <= prow_reg[AW-1:0];
                issue_reg <= 1'b1;
                vld_reg   <= 1'b0;
              end
            end
          end
        end

        SWAP0: state_reg <= SWAP1;

        SWAP1: begin
          state_reg <= ELIM;
          addr_reg  <= '0;
          issue_reg <= 1'b1;
          vld_reg   <= 1'b0;
        end

        ELIM: begin
          if (vld_reg && rrow_reg == LAST_ROW) begin
            prow_reg <= prow_inc;
            col_reg  <= col_reg + 1'b1;
            if (col_reg == LAST_COL || prow_inc == M_RW) begin
`ifdef GF2_ELIM_CONSIST_EN
              if (prow_inc == M_RW) begin
                state_reg <= DONE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end else begin
                state_reg <= CHECK;
                addr_reg  <= prow_inc[AW-1:0];
                issue_reg <= 1'b1;
                vld_reg   <= 1'b0;
              end
`else
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
`endif
            end else begin
              state_reg <= SRCH;
              addr_reg  <= prow_inc[AW-1:0];
              issue_reg <= 1'b1;
              vld_reg   <= 1'b0;
            end
          end
        end

`ifdef GF2_ELIM_CONSIST_EN
        CHECK: begin
          if (vld_reg) begin
            if (rd_data[N]) cons_reg <= 1'b0;
            if (rrow_reg == LAST_ROW) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_elim_ctrl.sv
// Bench for gf2_elim_ctrl with M=4, N=4: behavioural matrix-level model,
// RAM model, directed vectors, one negedge compare process.
module tb_gf2_elim_ctrl;

  localparam int M = 4;
  localparam int N = 4;
`ifdef GF2_ELIM_CONSIST_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, consistent;
  logic [8:0] rank;

  gf2_elim_ctrl_if #(.N(N)) host_if ();
  gf2_elim_ctrl_if #(.N(N)) ram_if ();

  gf2_elim_ctrl #(.M(M), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rank      (rank),
    .consistent(consistent),
    .host      (host_if),
    .ram       (ram_if)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, write visible to the next cycle's read
  logic [N:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_if.wr_en) mem[ram_if.w_addr] <= ram_if.w_data;
    ram_if.r_data <= mem[ram_if.r_addr];
  end

  // Expectations posted by the stimulus, consumed by the compare process
  string       q_name [512];
  logic [31:0] q_act  [512];
  logic [31:0] q_exp  [512];
  int          q_wr = 0;
  int          arm_seq = 0, abort_seq = 0;
  int          exp_cost = 0, exp_rank = 0;
  bit          exp_cons = 1'b1;

  // Behavioural model state
  logic [N:0] m_rows [M];
  int         m_rank, m_cost;
  bit         m_cons;

  task automatic post(input string nm, input logic [31:0] a, input logic [31:0] e);
    q_name[q_wr] = nm;
    q_act[q_wr]  = a;
    q_exp[q_wr]  = e;
    q_wr++;
  endtask

  // Matrix-level Gauss-Jordan with the cycle costs of each phase
  task automatic model_run();
    int prow;
    int p;
    logic [N:0] t;
    prow   = 0;
    m_cost = 0;
    for (int c = 0; c < N; c++) begin
      if (prow == M) break;
      p = -1;
      for (int r = prow; r < M; r++) if (p < 0 && m_rows[r][c]) p = r;
      if (p < 0) begin
        m_cost += M - prow + 1;
        continue;
      end
      m_cost += p - prow + 2;
      if (p != prow) begin
        t = m_rows[p]; m_rows[p] = m_rows[prow]; m_rows[prow] = t;
        m_cost += 2;
      end
      for (int r = 0; r < M; r++)
        if (r != prow && m_rows[r][c]) m_rows[r] = m_rows[r] ^ m_rows[prow];
      m_cost += M + 1;
      prow++;
    end
    m_rank = prow;
    m_cons = 1'b1;
    if (CHK_EN) begin
      for (int r = 0; r < M; r++)
        if (m_rows[r][N-1:0] == '0 && m_rows[r][N]) m_cons = 1'b0;
      if (m_rank < M) m_cost += M - m_rank + 1;
    end
  endtask

  // Compare process: per-cycle busy/done/result checks plus posted checks
  int n_cmp = 0, n_bad = 0, q_rd = 0;

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, a, e);
    end
  endtask

  initial begin : compare
    int  arm_seen, abort_seen, k;
    bit  act;
    arm_seen = 0; abort_seen = 0; k = 0; act = 1'b0;
    forever begin
      @(negedge clk);
      if (abort_seq != abort_seen) begin
        abort_seen = abort_seq;
        act = 1'b0;
      end
      if (arm_seq != arm_seen) begin
        arm_seen = arm_seq;
        act = 1'b1;
        k = 0;
      end
      if (act) begin
        check($sformatf("busy@%0d", k), {31'd0, busy}, {31'd0, (k < exp_cost)});
        check($sformatf("done@%0d", k), {31'd0, done}, {31'd0, (k == exp_cost)});
        if (k == exp_cost) begin
          check("rank", {23'd0, rank}, exp_rank);
          check("consistent", {31'd0, consistent}, {31'd0, exp_cons});
          act = 1'b0;
        end
        k++;
      end
      while (q_rd < q_wr) begin
        check(q_name[q_rd], q_act[q_rd], q_exp[q_rd]);
        q_rd++;
      end
    end
  end

  task automatic load(input logic [N:0] r0, r1, r2, r3);
    logic [N:0] v [4];
    v[0] = r0; v[1] = r1; v[2] = r2; v[3] = r3;
    for (int i = 0; i < M; i++) begin
      host_if.wr_en  = 1'b1;
      host_if.w_addr = 8'(i);
      host_if.w_data = v[i];
      @(posedge clk); #1;
    end
    host_if.wr_en = 1'b0;
    m_rows[0] = r0; m_rows[1] = r1; m_rows[2] = r2; m_rows[3] = r3;
  endtask

  task automatic kick();
    exp_cost = m_cost;
    exp_rank = m_rank;
    exp_cons = m_cons;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    arm_seq++;
  endtask

  task automatic run_case(input string nm, input logic [N:0] r0, r1, r2, r3, input bit arb,
                          input int lit_rank, input int lit_cost, input logic [N:0] lit_row1);
    int t;
    load(r0, r1, r2, r3);
    model_run();
    post({nm, " pin_rank"}, m_rank, lit_rank);
    post({nm, " pin_cost"}, m_cost, lit_cost);
    post({nm, " pin_row1"}, {27'd0, m_rows[1]}, {27'd0, lit_row1});
    kick();
    if (arb) begin
      for (int i = 0; i < 6; i++) begin
        host_if.wr_en  = 1'b1;
        host_if.w_addr = 8'(i % 4);
        host_if.w_data = '1;
        start = (i == 2);
        @(posedge clk); #1;
      end
      host_if.wr_en = 1'b0;
      start = 1'b0;
    end
    t = 0;
    while (!done && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    post({nm, " done_seen"}, {31'd0, done}, 1);
    post({nm, " rank_lit"}, {23'd0, rank}, lit_rank);
    for (int i = 0; i < M; i++) begin
      host_if.r_addr = 8'(i);
      @(posedge clk); #1;
      post($sformatf("%s row%0d", nm, i), {27'd0, host_if.r_data}, {27'd0, m_rows[i]});
    end
    $display("run %s: rank=%0d consistent=%0d wait=%0d", nm, rank, consistent, t);
  endtask

  initial begin : stim
    host_if.wr_en  = 1'b0;
    host_if.w_addr = '0;
    host_if.w_data = '0;
    host_if.r_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    post("reset busy", {31'd0, busy}, 0);
    post("reset done", {31'd0, done}, 0);
    post("reset rank", {23'd0, rank}, 0);
    post("reset consistent", {31'd0, consistent}, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_case("identity", 5'b0_0001, 5'b0_0010, 5'b0_0100, 5'b0_1000, 1'b0, 4, 28, 5'b0_0010);
    run_case("swap", 5'b0_0010, 5'b0_0001, 5'b1_0100, 5'b0_1000, 1'b0, 4, 31, 5'b0_0010);
    run_case("dependent", 5'b1_0011, 5'b1_0011, 5'b0, 5'b0, 1'b0, 1, CHK_EN ? 23 : 19, 5'b0_0000);
    run_case("inconsistent", 5'b0_0011, 5'b1_0011, 5'b0, 5'b0, 1'b0, 1, CHK_EN ? 23 : 19, 5'b1_0000);
    post("inconsistent pin_cons", {31'd0, m_cons}, CHK_EN ? 0 : 1);
    run_case("arbitration", 5'b0_0010, 5'b0_0001, 5'b1_0100, 5'b0_1000, 1'b1, 4, 31, 5'b0_0010);

    // Reset in the third ELIM pass, when rank is already 2
    load(5'b0_0010, 5'b0_0001, 5'b1_0100, 5'b0_1000);
    model_run();
    kick();
    repeat (20) begin
      @(posedge clk); #1;
    end
    post("midop rank_before", {23'd0, rank}, 2);
    abort_seq++;
    rst_n = 1'b0;
    #1;
    post("midop busy", {31'd0, busy}, 0);
    post("midop done", {31'd0, done}, 0);
    post("midop rank", {23'd0, rank}, 0);
    post("midop consistent", {31'd0, consistent}, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_case("after_reset", 5'b0_0010, 5'b0_0001, 5'b1_0100, 5'b0_1000, 1'b0, 4, 31, 5'b0_0010);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gf2_elim_ctrl.md
# gf2_elim_ctrl

Sequencer that performs in-place Gauss-Jordan elimination over GF(2) on the augmented matrix held in the matrix RAM. Row r is a word of N+1 bits: bits [N-1:0] are coefficients, bit N is the right-hand side. The block owns the RAM ports: it forwards host accesses while idle and drives the RAM itself while busy. On completion it reports the rank and whether the system is consistent.

## Interface
- M, 256: number of matrix rows; must be ≤ 256.
- N, 128: number of coefficient columns; row width is N+1.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins elimination; ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when elimination finishes
- rank  out  9  number of pivots found; valid from done until the next start
- consistent  out  1  no row of the form 0…0 | 1 is present; valid with rank
- h_wr_en, h_w_addr[7:0], h_w_data[N:0], h_r_addr[7:0]  in  host-side RAM request
- h_r_data  out  N+1  host read data, equal to ram_r_data
- ram_wr_en, ram_w_addr[7:0], ram_w_data[N:0], ram_r_addr[7:0]  out  RAM-side drive
- ram_r_data  in  N+1  RAM read data; valid one cycle after ram_r_addr is presented

## Operation
- **Reset values:** busy=0, done=0, rank=0, consistent=1, state=IDLE.
- **IDLE:** RAM ports are combinationally muxed from the host ports. Host writes are dropped while busy. Host reads while busy return whatever the controller is reading.
- **Internal state:** col (current column), prow (next pivot row), top_reg (N+1), piv_reg (N+1).
- **SRCH:** issue reads for rows prow..M-1, one row per cycle.
  - Capture the data of row prow into top_reg.
  - The first returned row with bit col = 1 becomes the pivot: its row index p and its data go into piv_reg. Any remaining in-flight reads are discarded.
  - If no row has the bit set, col increments and the block re-enters SRCH, or goes to CHECK when col reaches N.
- **SWAP0 / SWAP1:** entered only if p ≠ prow.
  - SWAP0 writes piv_reg to row prow.
  - SWAP1 writes top_reg to row p.
  - If p = prow, go straight to ELIM.
- **ELIM:** read rows 0..M-1, one per cycle.
  - For each returned row r ≠ prow with bit col = 1, write r ^ piv_reg to row r in the same cycle the data returns.
  - Row prow is never written.
  - At the end: prow++, rank++, col++.
  - Next state is CHECK if col = N or prow = M; otherwise SRCH.
- **CHECK:** read rows rank..M-1. Any returned row with bit N = 1 clears consistent. The scan is skipped when rank = M.
- **DONE:** pulse done for one cycle, then return to IDLE.
- **rank width:** rank counts up to min(M,N) ≤ 256, hence 9 bits.
- **start:** an accepted start resets rank=0 and consistent=1.
- **Reset mid-operation:** the block returns immediately to IDLE. RAM contents are then undefined, and the host must reload the matrix.

## Timing
- RAM read latency is exactly 1 cycle. Write data is visible to a read address presented in the cycle after the write.
- **SRCH cost:** (p − prow + 2) cycles when a pivot is found; (M − prow + 1) cycles when none is found.
- **Swap cost:** SWAP costs 2 cycles. There is no read/write hazard: a SWAP write lands before any ELIM read.
- **ELIM cost:** M + 1 cycles. The write in cycle t+1 targets row t, while the read in the same cycle targets row t+1, so the two never conflict.
- **CHECK cost:** (M − rank + 1) cycles.
- **done:** asserted one cycle after the last state finishes. busy falls in the same cycle done rises.
- **Rank 0:** a zero matrix gives N SRCH passes, then CHECK over all rows.

## Configuration
- **GF2_ELIM_CONSIST_EN defined:** the CHECK state exists and consistent is computed as described above.
- **Not defined:** CHECK is omitted, consistent is tied to 1, and the flow goes straight to DONE after the last column.

## Structure
- Package gf2_elim_pkg holds:
  - the state enum (IDLE, SRCH, SWAP0, SWAP1, ELIM, CHECK, DONE);
  - the address-width constant AW=8;
  - the rank width RW=9.
- One sub-module, gf2_row_update, is natural: combinational XOR of the row with piv_reg, and the write-enable decision based on the col bit and r ≠ prow.
- The RAM itself is instantiated outside this block; the controller only drives its ports.

## Test plan
- **M=4, N=4, identity loaded:** start → no swaps, no ELIM writes, rank=4, consistent=1, done after ≤ 30 cycles.
- **M=4, N=4:** rows {0b0_0010, 0b0_0001, 0b1_0100, 0b0_1000} → swap of rows 0 and 1, final matrix is the identity with RHS bit 1 only in row 2, rank=4.
- **Dependent system:** rows {0b1_0011, 0b1_0011, 0, 0} → rank=1, row 1 becomes 0b0_0000, consistent=1.
- **Inconsistent system:** rows {0b0_0011, 0b1_0011, 0, 0} → row 1 becomes 0b1_0000, consistent=0. With the macro undefined, consistent=1.
- **Arbitration:** host writes issued while busy leave the RAM unchanged. A start pulse during busy is ignored, with no restart.
- **Reset mid-operation:** rst_n low during ELIM → busy=0, done=0, rank=0, consistent=1 immediately. A new start after reload completes correctly.
